// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation through load, execute, latch and capture phases,
// then holds the result on a valid/ready response channel until it is taken.
module alu_op_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_funct3,
  output logic [WIDTH-1:0] regA_data,
  output logic [WIDTH-1:0] regB_data,
  output logic             regA_ctrl,
  output logic             regB_ctrl,
  output logic             ALUOUT_ctrl,
  output logic [2:0]       funct3,
  input  logic [WIDTH-1:0] aluout_in,
  input  logic             cmp_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cmp,
  output logic             busy,
  output logic [7:0]       done_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [3:0]       r_exec_cnt;
  logic [WIDTH-1:0] r_rega;
  logic [WIDTH-1:0] r_regb;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_cmp;
  logic [7:0]       r_done;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (req_valid) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_EXEC;
      S_EXEC:    if (r_exec_cnt == EXEC_LAST) w_state_nxt = S_LATCH;
      S_LATCH:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_exec_cnt <= '0;
      r_rega     <= '0;
      r_regb     <= '0;
      r_funct3   <= '0;
      r_rsp_data <= '0;
      r_rsp_cmp  <= 1'b0;
      r_done     <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_rega   <= req_a;
            r_regb   <= req_b;
            r_funct3 <= req_funct3;
          end
        end
        S_EXEC: begin
          if (r_exec_cnt == EXEC_LAST) r_exec_cnt <= '0;
          else                         r_exec_cnt <= r_exec_cnt + 4'd1;
        end
        S_LATCH:   r_rsp_cmp  <= cmp_in;
        S_CAPTURE: r_rsp_data <= aluout_in;
        S_RESP:    if (rsp_ready) r_done <= r_done + 8'd1;
        default: ;
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 while reset is held, even though state is IDLE.
  assign req_ready   = reset && (r_state == S_IDLE);
  assign regA_ctrl   = (r_state == S_LOAD);
  assign regB_ctrl   = (r_state == S_LOAD);
  assign ALUOUT_ctrl = (r_state == S_LATCH);
  assign rsp_valid   = (r_state == S_RESP);
  assign busy        = (r_state != S_IDLE);
  assign regA_data   = r_rega;
  assign regB_data   = r_regb;
  assign funct3      = r_funct3;
  assign rsp_data    = r_rsp_data;
  assign rsp_cmp     = r_rsp_cmp;
  assign done_count  = r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a small external ALU
// model; a second instance with EXEC_CYCLES=4 checks the longer latency.
module tb_alu_op_sequencer;

  localparam int E = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [2:0]  req_funct3 = '0;
  logic [15:0] regA_data, regB_data;
  logic        regA_ctrl, regB_ctrl, ALUOUT_ctrl;
  logic [2:0]  funct3;
  logic [15:0] aluout_in;
  logic        cmp_in;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_cmp;
  logic        busy;
  logic [7:0]  done_count;

  // Second instance, EXEC_CYCLES=4
  logic        d4_req_valid = 1'b0;
  logic        d4_req_ready;
  logic [15:0] d4_rega, d4_regb;
  logic        d4_regA_ctrl, d4_regB_ctrl, d4_ALUOUT_ctrl;
  logic [2:0]  d4_funct3;
  logic        d4_rsp_valid;
  logic        d4_rsp_ready = 1'b0;
  logic [15:0] d4_rsp_data;
  logic        d4_rsp_cmp;
  logic        d4_busy;
  logic [7:0]  d4_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.WIDTH(16), .EXEC_CYCLES(E)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_funct3(req_funct3),
    .regA_data(regA_data), .regB_data(regB_data), .regA_ctrl(regA_ctrl),
    .regB_ctrl(regB_ctrl), .ALUOUT_ctrl(ALUOUT_ctrl), .funct3(funct3),
    .aluout_in(aluout_in), .cmp_in(cmp_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cmp(rsp_cmp),
    .busy(busy), .done_count(done_count)
  );

  alu_op_sequencer #(.WIDTH(16), .EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req_a(16'h0011), .req_b(16'h0022), .req_funct3(3'd5),
    .regA_data(d4_rega), .regB_data(d4_regb), .regA_ctrl(d4_regA_ctrl),
    .regB_ctrl(d4_regB_ctrl), .ALUOUT_ctrl(d4_ALUOUT_ctrl), .funct3(d4_funct3),
    .aluout_in(16'h1234), .cmp_in(1'b1), .rsp_valid(d4_rsp_valid),
    .rsp_ready(d4_rsp_ready), .rsp_data(d4_rsp_data), .rsp_cmp(d4_rsp_cmp),
    .busy(d4_busy), .done_count(d4_done)
  );

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] f);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      3'd5:    return {15'd0, $signed(a) < $signed(b)};
      3'd6:    return a << b[3:0];
      default: return ~a;
    endcase
  endfunction

  // External A/B/ALUOUT registers driven by the sequencer's load enables
  logic [15:0] alu_a = '0, alu_b = '0, alu_out = '0;
  always @(posedge clk) begin
    if (regA_ctrl)   alu_a   <= regA_data;
    if (regB_ctrl)   alu_b   <= regB_data;
    if (ALUOUT_ctrl) alu_out <= alu_ref(alu_a, alu_b, funct3);
  end
  assign aluout_in = alu_out;
  assign cmp_in    = $signed(alu_a) < $signed(alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Scoreboard / monitor
  typedef struct packed { logic [15:0] data; logic cmp; } rsp_t;
  rsp_t        sb_q[$];
  bit          active = 0;
  int          acc = 0;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic [2:0]  exp_f = '0;
  logic [7:0]  exp_done = '0;
  bit          prev_valid = 0;
  logic [15:0] prev_data = '0;
  logic        prev_cmp = 1'b0;

  always @(negedge clk) begin
    int   k;
    bit   exp_valid;
    rsp_t e;
    if (!reset) begin
      active = 0; sb_q.delete(); exp_a = '0; exp_b = '0; exp_f = '0;
      exp_done = '0; prev_valid = 0;
    end else begin
      k = cyc - acc;
      exp_valid = active && (k >= 3 + E);
      chk("regA_data", regA_data, exp_a);
      chk("regB_data", regB_data, exp_b);
      chk("funct3", funct3, exp_f);
      chk("req_ready", req_ready, !active);
      chk("busy", busy, active);
      chk("regA_ctrl", regA_ctrl, active && k == 0);
      chk("regB_ctrl", regB_ctrl, active && k == 0);
      chk("ALUOUT_ctrl", ALUOUT_ctrl, active && k == 1 + E);
      chk("ctrl_onehot", $countones({regA_ctrl, ALUOUT_ctrl}) <= 1, 1);
      chk("rsp_valid", rsp_valid, exp_valid);
      chk("done_count", done_count, exp_done);
      if (prev_valid && rsp_valid) begin
        chk("rsp_data_stable", rsp_data, prev_data);
        chk("rsp_cmp_stable", rsp_cmp, prev_cmp);
      end
      if (exp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cmp", rsp_cmp, e.cmp);
        end
        exp_done = exp_done + 8'd1;
        active = 0;
      end else if (!active && req_valid) begin
        e.data = alu_ref(req_a, req_b, req_funct3);
        e.cmp  = $signed(req_a) < $signed(req_b);
        sb_q.push_back(e);
        exp_a = req_a; exp_b = req_b; exp_f = req_funct3;
        active = 1;
        acc = cyc + 1;
      end
      prev_valid = rsp_valid; prev_data = rsp_data; prev_cmp = rsp_cmp;
    end
  end

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", {regA_ctrl, regB_ctrl, ALUOUT_ctrl}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_regA", regA_data, 0);
    chk("rst_regB", regB_data, 0);
    chk("rst_funct3", funct3, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_cmp", rsp_cmp, 0);
    chk("rst_done", done_count, 0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                       input int hold, input bit junk, input bit nosync, output int waits);
    int n;
    if (!nosync) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_a = a; req_b = b; req_funct3 = f; rsp_ready = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits > 50) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (junk) begin
      req_valid = 1'b1; req_a = ~a ^ 16'h5A5A; req_b = b + 16'd77; req_funct3 = f + 3'd3;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
      if (n > 50) begin chk("rsp_timeout", 0, 1); break; end
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    #3 check_reset_vals();
    // Request presented while reset is released: taken on the first rising edge
    @(posedge clk); #1;
    reset = 1'b1;
    do_op(16'd100, -16'sd30, 3'd0, 0, 0, 1, w);
    chk("first_edge_accept", w, 0);
    do_op(16'h00F0, 16'h0F0F, 3'd2, 5, 0, 0, w);
    do_op(16'h1111, 16'h2222, 3'd4, 1, 1, 0, w);
    for (int i = 0; i < 20; i++)
      do_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3), i[0], 0, w);

    // Reset in the middle of EXEC aborts the operation
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = 16'd9; req_b = 16'd4; req_funct3 = 3'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);

    // Full wrap of done_count, including a guaranteed compare=1 case
    for (int i = 0; i < 256; i++) begin
      if (i == 7) do_op(-16'sd5, 16'd3, 3'd5, 0, 0, 0, w);
      else do_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2), 0, 0, w);
    end
    @(negedge clk);
    chk("done_wrap", done_count, 0);

    // EXEC_CYCLES=4 instance: latency 7, funct3 stable, ALUOUT_ctrl on edge 5
    @(posedge clk); #1;
    d4_req_valid = 1'b1;
    @(negedge clk);
    chk("d4_req_ready", d4_req_ready, 1);
    @(posedge clk); #1;
    d4_req_valid = 1'b0;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (d4_rsp_valid || n > 20) break;
      chk("d4_funct3_stable", d4_funct3, 5);
      chk("d4_aluout_ctrl", d4_ALUOUT_ctrl, n == 5);
    end
    chk("d4_latency", n, 7);
    chk("d4_rsp_data", d4_rsp_data, 16'h1234);
    chk("d4_rsp_cmp", d4_rsp_cmp, 1);
    d4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    d4_rsp_ready = 1'b0;
    chk("d4_done", d4_done, 1);
    chk("d4_idle", d4_busy, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
